store_buffer: RTL and testbench

Posted-write buffer between the pipeline MEM stage and a multi-cycle data memory port. Stores from the EX/MEM register are queued in a FIFO and accepted with no stall while space remains. Queued stores drain to memory in order over a req/ack handshake. Loads stall the pipeline until they complete, and they wait for the buffer to drain first when their word address matches a queued store.

---
 rtl/store_buffer.sv | 156 +++++++++++++++
 tb/tb_store_buffer.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
// store_buffer: posted-write FIFO between the MEM stage and the data memory.
// Stores drain in order; loads stall and wait on a word-address conflict.
module store_buffer #(
    parameter int DATA_W     = 32,
    parameter int DM_ADDRESS = 9,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr,
    input  logic                  reade,
    input  logic [DM_ADDRESS-1:0] addr,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic [2:0]            func3,
    output logic [DATA_W-1:0]     rd_data,
    output logic                  stall,
    output logic                  empty,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [DM_ADDRESS-1:0] mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [2:0]            mem_func3,
    input  logic                  mem_ack,
    input  logic [DATA_W-1:0]     mem_rdata
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] LD_WAIT = 2'd2;
    localparam logic [1:0] LD_DONE = 2'd3;

    logic [DM_ADDRESS-1:0] q_addr  [DEPTH];
    logic [DATA_W-1:0]     q_data  [DEPTH];
    logic [2:0]            q_func3 [DEPTH];
    logic [DEPTH-1:0]      q_valid;

    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;
    logic [1:0]    state;

    logic full;
    logic ld_pend;
    logic conflict;
    logic ld_go;
    logic ack;
    logic push;
    logic pop;

    assign full    = (count == CW'(DEPTH));
    assign ld_pend = reade & (state != LD_DONE);
    assign ack     = mem_ack & mem_req;
    assign push    = wr & ~reade & ~full;
    assign pop     = (state == ST_WAIT) & ack;
    assign ld_go   = ld_pend & ~conflict;

    // A load conflicts with any queued store to the same word
    always_comb begin
        conflict = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (q_valid[i] &&
                q_addr[i][DM_ADDRESS-1:2] == addr[DM_ADDRESS-1:2]) begin
                conflict = 1'b1;
            end
        end
    end

    assign stall = ~reset & (ld_pend | (wr & ~reade & full));
    assign empty = (count == '0) & (state != ST_WAIT);

    // Entry payloads need no reset; the valid bits qualify them
    always_ff @(posedge clk) begin
        if (push) begin
            q_addr[tail]  <= addr;
            q_data[tail]  <= wr_data;
            q_func3[tail] <= func3;
        end
    end

    // Pointer, occupancy and valid-bit bookkeeping
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            q_valid <= '0;
        end else begin
            if (push) begin
                tail          <= tail + PW'(1);
                q_valid[tail] <= 1'b1;
            end
            if (pop) begin
                head          <= head + PW'(1);
                q_valid[head] <= 1'b0;
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

    // Memory-port sequencer: loads first, otherwise drain the head store
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_func3 <= '0;
            rd_data   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (ld_go) begin
                        state     <= LD_WAIT;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_addr  <= addr;
                        mem_wdata <= '0;
                        mem_func3 <= func3;
                    end else if (count != '0) begin
                        state     <= ST_WAIT;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_addr  <= q_addr[head];
                        mem_wdata <= q_data[head];
                        mem_func3 <= q_func3[head];
                    end
                end
                ST_WAIT: begin
                    if (ack) begin
                        state   <= IDLE;
                        mem_req <= 1'b0;
                    end
                end
                LD_WAIT: begin
                    if (ack) begin
                        state   <= LD_DONE;
                        mem_req <= 1'b0;
                        rd_data <= mem_rdata;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: randomized scoreboard bench for store_buffer.
// A word memory model answers the port; a program-order model predicts loads.
module tb_store_buffer;

    localparam int DW    = 32;
    localparam int AW    = 9;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          wr;
    logic          reade;
    logic [AW-1:0] addr;
    logic [DW-1:0] wr_data;
    logic [2:0]    func3;
    logic [DW-1:0] rd_data;
    logic          stall;
    logic          empty;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [2:0]    mem_func3;
    logic          mem_ack;
    logic [DW-1:0] mem_rdata;

    store_buffer #(.DATA_W(DW), .DM_ADDRESS(AW), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .wr(wr), .reade(reade), .addr(addr),
        .wr_data(wr_data), .func3(func3), .rd_data(rd_data),
        .stall(stall), .empty(empty), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_func3(mem_func3),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [2:0]    f;
    } txn_t;

    txn_t          wq[$];
    txn_t          rq[$];
    logic [DW-1:0] lq[$];
    logic [AW-1:0] tlog[$];
    logic [DW-1:0] ref_mem[128];
    logic [DW-1:0] mem[128];

    int   checks = 0;
    int   errors = 0;
    logic ack_en = 1'b1;
    logic lat_rand = 1'b0;
    int   ack_lat = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic bound_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual=timeout required=completion", name);
    endtask

    // Memory responder: ack after a programmable or random delay
    int   cnt = 0;
    logic in_txn = 1'b0;
    initial begin
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_ack) begin
                mem_ack = 1'b0;
                in_txn  = 1'b0;
            end else if (mem_req && !reset) begin
                if (!in_txn) begin
                    in_txn = 1'b1;
                    cnt = lat_rand ? int'($urandom_range(0, 3)) : ack_lat;
                end
                if (ack_en) begin
                    if (cnt == 0) begin
                        mem_ack = 1'b1;
                        if (mem_we) mem[mem_addr[AW-1:2]] = mem_wdata;
                        else mem_rdata = mem[mem_addr[AW-1:2]];
                    end else begin
                        cnt--;
                    end
                end
            end else begin
                in_txn = 1'b0;
            end
        end
    end

    // Monitor: compares every memory request and load result to the queues
    logic          p_req = 1'b0;
    logic          p_ack = 1'b0;
    logic          p_we;
    logic [AW-1:0] p_addr;
    logic [DW-1:0] p_wd;
    logic [2:0]    p_f;
    int            ld_st = 0;
    txn_t          m_e;
    int            m_n;
    always @(negedge clk) begin
        if (reset) begin
            p_req = 1'b0;
            p_ack = 1'b0;
            ld_st = 0;
        end else begin
            if (p_ack) chk("req_gap", 64'(mem_req), 64'd0);
            if (mem_req && p_req) begin
                chk("req_hold", {mem_we, mem_addr, mem_func3, mem_wdata},
                    {p_we, p_addr, p_f, p_wd});
            end else if (mem_req) begin
                tlog.push_back(mem_addr);
                if (mem_we) begin
                    if (wq.size() == 0) begin
                        bound_fail("unexpected_write");
                    end else begin
                        m_e = wq.pop_front();
                        chk("wr_fields", {mem_addr, mem_wdata, mem_func3},
                            {m_e.a, m_e.d, m_e.f});
                    end
                end else begin
                    if (rq.size() == 0) begin
                        bound_fail("unexpected_read");
                    end else begin
                        m_e = rq.pop_front();
                        chk("rd_fields", {mem_addr, mem_func3}, {m_e.a, m_e.f});
                    end
                    m_n = 0;
                    foreach (wq[i])
                        if (wq[i].a[AW-1:2] == mem_addr[AW-1:2]) m_n++;
                    chk("rd_conflict", 64'(m_n), 64'd0);
                end
            end
            if (reade && stall) begin
                ld_st++;
            end else if (reade) begin
                if (lq.size() == 0) bound_fail("unexpected_load_done");
                else chk("rd_data", rd_data, lq.pop_front());
                chk("ld_min_stall", 64'(ld_st >= 2), 64'd1);
                ld_st = 0;
            end
            p_req  = mem_req;
            p_ack  = mem_req & mem_ack;
            p_we   = mem_we;
            p_addr = mem_addr;
            p_wd   = mem_wdata;
            p_f    = mem_func3;
        end
    end

    task automatic do_store(input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input logic [2:0] f, output int w);
        txn_t e;
        w       = 0;
        wr      = 1'b1;
        addr    = a;
        wr_data = d;
        func3   = f;
        forever begin
            @(negedge clk);
            if (!stall) break;
            w++;
            if (w > 200) break;
            @(posedge clk);
            #1;
        end
        if (!stall) begin
            e.a = a;
            e.d = d;
            e.f = f;
            wq.push_back(e);
            ref_mem[a[AW-1:2]] = d;
        end else begin
            bound_fail("store_accept");
        end
        @(posedge clk);
        #1;
        wr = 1'b0;
    endtask

    task automatic do_load(input logic [AW-1:0] a, input logic [2:0] f);
        txn_t e;
        int   n;
        e.a = a;
        e.d = '0;
        e.f = f;
        rq.push_back(e);
        lq.push_back(ref_mem[a[AW-1:2]]);
        reade = 1'b1;
        addr  = a;
        func3 = f;
        n     = 0;
        forever begin
            @(negedge clk);
            if (!stall) break;
            n++;
            if (n > 300) begin
                bound_fail("load_complete");
                break;
            end
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        reade = 1'b0;
    endtask

    task automatic wait_empty(input string name);
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            if (empty && !mem_req) break;
            n++;
            if (n > 300) begin
                bound_fail(name);
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    int            w;
    int            w5;
    logic [AW-1:0] ra;
    initial begin
        for (int i = 0; i < 128; i++) begin
            mem[i]     = '0;
            ref_mem[i] = '0;
        end
        reset   = 1'b1;
        wr      = 1'b1;
        reade   = 1'b1;
        addr    = '0;
        wr_data = '0;
        func3   = '0;
        repeat (2) @(negedge clk);
        chk("rst_stall", 64'(stall), 64'd0);
        chk("rst_rd_data", rd_data, 64'd0);
        chk("rst_mem_req", 64'(mem_req), 64'd0);
        chk("rst_mem_we", 64'(mem_we), 64'd0);
        chk("rst_mem_addr", mem_addr, 64'd0);
        chk("rst_mem_wdata", mem_wdata, 64'd0);
        chk("rst_mem_func3", mem_func3, 64'd0);
        chk("rst_empty", 64'(empty), 64'd1);
        wr    = 1'b0;
        reade = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle(2);

        // single store with one-cycle ack latency
        ack_lat = 1;
        do_store(9'h010, 32'hDEADBEEF, 3'd2, w);
        chk("st1_nostall", 64'(w), 64'd0);
        chk("st1_req_lo", 64'(mem_req), 64'd0);
        chk("st1_busy", 64'(empty), 64'd0);
        repeat (2) @(negedge clk);
        chk("st1_req", {mem_req, mem_we, mem_addr, mem_wdata, mem_func3},
            {1'b1, 1'b1, 9'h010, 32'hDEADBEEF, 3'd2});
        w = 0;
        while (!mem_ack && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (!mem_ack) bound_fail("st1_ack");
        @(negedge clk);
        chk("st1_empty", 64'(empty), 64'd1);
        @(posedge clk);
        #1;

        // fill to full, fifth store stalls until a pop
        ack_lat = 0;
        ack_en  = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            do_store(AW'(9'h080 + 4 * i), $urandom, 3'(i), w);
            chk("full_st_nostall", 64'(w), 64'd0);
        end
        fork
            do_store(9'h090, 32'h5A5A0005, 3'd5, w5);
            begin
                repeat (3) @(negedge clk);
                ack_en = 1'b1;
                w = 0;
                do begin
                    @(negedge clk);
                    w++;
                end while (!mem_ack && w < 20);
                chk("full_pop_stall", 64'(stall), 64'd1);
                @(negedge clk);
                chk("full_unstall", 64'(stall), 64'd0);
            end
        join
        chk("full_st5_stalled", 64'(w5 >= 3), 64'd1);
        wait_empty("full_drain");
        chk("full_drained", 64'(wq.size()), 64'd0);

        // load behind a conflicting store
        ack_lat = 3;
        tlog.delete();
        do_store(9'h020, 32'h55, 3'd2, w);
        do_load(9'h022, 3'd2);
        chk("conf_rd", rd_data, 64'h55);
        chk("conf_order_n", 64'(tlog.size()), 64'd2);
        if (tlog.size() == 2) begin
            chk("conf_order0", tlog[0], 64'h020);
            chk("conf_order1", tlog[1], 64'h022);
        end
        wait_empty("conf_drain");

        // non-conflicting load bypasses the queued store
        ack_lat = 0;
        ack_en  = 1'b0;
        tlog.delete();
        do_store(9'h100, 32'h11110100, 3'd2, w);
        do_store(9'h104, 32'h22220104, 3'd2, w);
        fork
            do_load(9'h040, 3'd4);
            begin
                repeat (4) @(negedge clk);
                ack_en = 1'b1;
            end
        join
        wait_empty("byp_drain");
        chk("byp_order_n", 64'(tlog.size()), 64'd3);
        if (tlog.size() == 3) begin
            chk("byp_order0", tlog[0], 64'h100);
            chk("byp_order1", tlog[1], 64'h040);
            chk("byp_order2", tlog[2], 64'h104);
        end

        // reset during an outstanding load
        ack_en = 1'b0;
        rq.push_back('{a: 9'h044, d: '0, f: 3'd2});
        lq.push_back(ref_mem[9'h044 >> 2]);
        reade = 1'b1;
        addr  = 9'h044;
        func3 = 3'd2;
        repeat (2) @(negedge clk);
        chk("rml_req", 64'(mem_req), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("rml_req_async", 64'(mem_req), 64'd0);
        chk("rml_rd_data", rd_data, 64'd0);
        chk("rml_fields", {mem_we, mem_addr, mem_wdata, mem_func3}, 64'd0);
        chk("rml_empty", 64'(empty), 64'd1);
        chk("rml_stall", 64'(stall), 64'd0);
        rq.delete();
        lq.delete();
        reade  = 1'b0;
        ack_en = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle(1);
        do_store(9'h0C0, 32'hC0FFEE00, 3'd2, w);
        do_load(9'h0C1, 3'd1);
        wait_empty("rml_recover");

        // wrap-around with random ack delays
        lat_rand = 1'b1;
        for (int i = 0; i < 3 * DEPTH; i++) begin
            do_store(AW'(9'h180 + 4 * i), $urandom, 3'($urandom_range(0, 7)), w);
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
        end
        wait_empty("wrap_drain");
        chk("wrap_no_lost", 64'(wq.size()), 64'd0);

        // random mix of stores and loads over a small address window
        for (int i = 0; i < 80; i++) begin
            ra = AW'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
            if ($urandom_range(0, 2) != 0) do_store(ra, $urandom, 3'($urandom_range(0, 7)), w);
            else do_load(ra, 3'($urandom_range(0, 7)));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 4));
        end
        wait_empty("rand_drain");
        chk("end_wq", 64'(wq.size()), 64'd0);
        chk("end_rq", 64'(rq.size()), 64'd0);
        chk("end_lq", 64'(lq.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
